// File: rtl/load_store_unit_pkg.sv
// Shared constants and types for the load/store unit data cache refill path.
package load_store_unit_pkg;

   localparam int WAYS_NUMBER = 4;
   localparam int WAY_ADDR    = 2;
   localparam int PORT_WIDTH  = 32;
   localparam int TAG_SIZE    = 20;
   localparam int INDEX_SIZE  = 8;
   localparam int BLOCK_WORDS = 4;
   localparam int OFFSET_SIZE = 2;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ALLOCATE = 3'd1,
      REQUEST  = 3'd2,
      REFILL   = 3'd3,
      DONE     = 3'd4
   } refill_state_t;

endpackage

// File: rtl/data_cache_victim_select.sv
// Victim way selection: first invalid way wins; when the set is full a
// round-robin pointer chooses the way and advances on that allocation.
module data_cache_victim_select #(
   parameter int WAYS_NUMBER = load_store_unit_pkg::WAYS_NUMBER,
   parameter int WAY_ADDR    = load_store_unit_pkg::WAY_ADDR
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [WAYS_NUMBER-1:0] set_valid_i,
   input  logic                   allocate_i,
   output logic [WAY_ADDR-1:0]    victim_o
);

   logic [WAY_ADDR-1:0] rr_ptr_q;
   logic [WAY_ADDR-1:0] rr_ptr_d;
   logic [WAY_ADDR-1:0] first_free;
   logic                any_free;

   // Priority encoder: scanning downwards leaves the lowest free way selected.
   always_comb begin
      any_free   = 1'b0;
      first_free = '0;
      for (int i = WAYS_NUMBER - 1; i >= 0; i--) begin
         if (!set_valid_i[i]) begin
            any_free   = 1'b1;
            first_free = WAY_ADDR'(i);
         end
      end
   end

   assign victim_o = any_free ? first_free : rr_ptr_q;

   // Pointer only moves when it actually supplied the victim.
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (allocate_i && !any_free) begin
         rr_ptr_d = (rr_ptr_q == WAY_ADDR'(WAYS_NUMBER - 1)) ? '0 : rr_ptr_q + WAY_ADDR'(1);
      end
   end

   // Round-robin pointer register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rr_ptr_q <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end

endmodule

// File: rtl/data_cache_refill_controller.sv
// Data cache refill controller: on a read miss, allocates a victim way,
// streams the block in from memory and writes it into cache port 0. The tag
// and valid bit are written only with the final word.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  IDLE     | waiting for miss_i; latches tag and index
//  ALLOCATE | victim way chosen and latched
//  REQUEST  | memory request raised until the first word returns
//  REFILL   | remaining words written as they arrive
//  DONE     | one-cycle completion pulse
module data_cache_refill_controller
   import load_store_unit_pkg::refill_state_t;
   import load_store_unit_pkg::IDLE;
   import load_store_unit_pkg::ALLOCATE;
   import load_store_unit_pkg::REQUEST;
   import load_store_unit_pkg::REFILL;
   import load_store_unit_pkg::DONE;
#(
   parameter int WAYS_NUMBER = load_store_unit_pkg::WAYS_NUMBER,
   parameter int WAY_ADDR    = load_store_unit_pkg::WAY_ADDR,
   parameter int PORT_WIDTH  = load_store_unit_pkg::PORT_WIDTH,
   parameter int TAG_SIZE    = load_store_unit_pkg::TAG_SIZE,
   parameter int INDEX_SIZE  = load_store_unit_pkg::INDEX_SIZE,
   parameter int BLOCK_WORDS = load_store_unit_pkg::BLOCK_WORDS,
   parameter int OFFSET_SIZE = load_store_unit_pkg::OFFSET_SIZE
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           miss_i,
   input  logic [TAG_SIZE-1:0]            miss_tag_i,
   input  logic [INDEX_SIZE-1:0]          miss_index_i,
   input  logic [WAYS_NUMBER-1:0]         set_valid_i,
   output logic                           refill_busy_o,
   output logic                           refill_done_o,
   output logic                           mem_request_o,
   output logic [TAG_SIZE+INDEX_SIZE-1:0] mem_address_o,
   input  logic [PORT_WIDTH-1:0]          mem_data_i,
   input  logic                           mem_valid_i,
   output logic                           cache_write_o,
   output logic [WAY_ADDR-1:0]            cache_way_o,
   output logic [INDEX_SIZE-1:0]          cache_index_o,
   output logic [OFFSET_SIZE-1:0]         cache_offset_o,
   output logic [PORT_WIDTH-1:0]          cache_data_o,
   output logic                           cache_tag_write_o,
   output logic [TAG_SIZE-1:0]            cache_tag_o
);

   refill_state_t          state_q, state_d;
   logic [TAG_SIZE-1:0]    tag_q, tag_d;
   logic [INDEX_SIZE-1:0]  index_q, index_d;
   logic [WAY_ADDR-1:0]    way_q, way_d;
   logic [OFFSET_SIZE-1:0] word_q, word_d;
   logic [WAY_ADDR-1:0]    victim;
   logic                   last_word;

   data_cache_victim_select #(
      .WAYS_NUMBER (WAYS_NUMBER),
      .WAY_ADDR    (WAY_ADDR)
   ) u_victim_select (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .set_valid_i (set_valid_i),
      .allocate_i  (state_q == ALLOCATE),
      .victim_o    (victim)
   );

   assign last_word = (word_q == OFFSET_SIZE'(BLOCK_WORDS - 1));

   // Next-state and output decode; everything is zero in IDLE.
   always_comb begin
      state_d           = state_q;
      tag_d             = tag_q;
      index_d           = index_q;
      way_d             = way_q;
      word_d            = word_q;
      refill_busy_o     = 1'b0;
      refill_done_o     = 1'b0;
      mem_request_o     = 1'b0;
      mem_address_o     = '0;
      cache_write_o     = 1'b0;
      cache_way_o       = '0;
      cache_index_o     = '0;
      cache_offset_o    = '0;
      cache_data_o      = '0;
      cache_tag_write_o = 1'b0;
      cache_tag_o       = '0;

      if (state_q != IDLE) begin
         refill_busy_o = 1'b1;
         mem_address_o = {tag_q, index_q};
         cache_way_o   = way_q;
         cache_index_o = index_q;
         cache_tag_o   = tag_q;
      end

      // Memory words are only accepted while the line is being filled.
      if ((state_q == REQUEST) || (state_q == REFILL)) begin
         cache_write_o     = mem_valid_i;
         cache_data_o      = mem_data_i;
         cache_offset_o    = word_q;
         cache_tag_write_o = mem_valid_i && last_word;
         if (mem_valid_i) begin
            word_d = last_word ? '0 : word_q + OFFSET_SIZE'(1);
         end
      end

      case (state_q)
         IDLE: begin
            if (miss_i) begin
               tag_d   = miss_tag_i;
               index_d = miss_index_i;
               state_d = ALLOCATE;
            end
         end
         ALLOCATE: begin
            cache_way_o = victim;
            way_d       = victim;
            state_d     = REQUEST;
         end
         REQUEST: begin
            mem_request_o = 1'b1;
            if (mem_valid_i) begin
               state_d = last_word ? DONE : REFILL;
            end
         end
         REFILL: begin
            if (mem_valid_i && last_word) begin
               state_d = DONE;
            end
         end
         DONE: begin
            refill_done_o = 1'b1;
            state_d       = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and latched request registers; reset aborts any refill in flight.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         tag_q   <= '0;
         index_q <= '0;
         way_q   <= '0;
         word_q  <= '0;
      end else begin
         state_q <= state_d;
         tag_q   <= tag_d;
         index_q <= index_d;
         way_q   <= way_d;
         word_q  <= word_d;
      end
   end

endmodule
